// File: rtl/beep_timer_pkg.sv
// Shared types and helpers for the beep_timer alert stage.
package beep_timer_pkg;

   typedef enum logic [2:0] {
      IDLE,
      COUNT,
      BEEP_ON,
      BEEP_OFF,
      DONE
   } bt_state_t;

   // A request for zero pulses still produces one pulse.
   function automatic int unsigned pulse_total(input int unsigned n);
      return (n == 0) ? 1 : n;
   endfunction

endpackage

// File: rtl/beep_pattern_gen.sv
// ON/OFF pulse train generator: phase counter, pulse index and registered beep output.
module beep_pattern_gen
   import beep_timer_pkg::*;
#(
   parameter int unsigned NB_W    = 2,
   parameter int unsigned ON_CYC  = 3,
   parameter int unsigned OFF_CYC = 2
) (
   input  logic            clk_i,
   input  logic            rst_i,
   input  logic            clr_i,
   input  logic            start_i,
   input  logic [NB_W-1:0] pulses_i,
   output logic            b_o,
   output logic            last_o,
   output logic            phase_zero_o
);

   localparam int unsigned PH_MAX = (ON_CYC > OFF_CYC) ? ON_CYC : OFF_CYC;
   localparam int unsigned PH_W   = (PH_MAX > 1) ? $clog2(PH_MAX) : 1;

   logic            active_q;
   logic            b_q;
   logic [PH_W-1:0] phase_q;
   logic [NB_W-1:0] idx_q;
   logic [NB_W-1:0] total_q;

   assign phase_zero_o = (phase_q == '0);
   assign last_o       = active_q && b_q && phase_zero_o && (idx_q == total_q - NB_W'(1));
   assign b_o          = b_q;

   always_ff @(posedge clk_i) begin
      if (rst_i || clr_i) begin
         active_q <= 1'b0;
         b_q      <= 1'b0;
         phase_q  <= '0;
         idx_q    <= '0;
         total_q  <= '0;
      end else if (start_i) begin
         active_q <= 1'b1;
         b_q      <= 1'b1;
         phase_q  <= PH_W'(ON_CYC - 1);
         idx_q    <= '0;
         total_q  <= NB_W'(pulse_total(32'(pulses_i)));
      end else if (active_q) begin
         if (!phase_zero_o) begin
            phase_q <= phase_q - PH_W'(1);
         end else if (b_q) begin
            b_q <= 1'b0;
            if (last_o) begin
               active_q <= 1'b0;
               idx_q    <= '0;
            end else begin
               phase_q <= PH_W'(OFF_CYC - 1);
               idx_q   <= idx_q + NB_W'(1);
            end
         end else begin
            b_q     <= 1'b1;
            phase_q <= PH_W'(ON_CYC - 1);
         end
      end
   end

endmodule

// File: rtl/beep_timer.sv
// Countdown timer followed by a programmable beep train, with optional auto-reload.
module beep_timer
   import beep_timer_pkg::*;
#(
   parameter int unsigned WIDTH   = 8,
   parameter int unsigned NB_W    = 2,
   parameter int unsigned ON_CYC  = 3,
   parameter int unsigned OFF_CYC = 2
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic [WIDTH-1:0] v,
   input  logic [NB_W-1:0]  n_beeps,
   input  logic             auto_reload,
   output logic             b,
   output logic             busy,
   output logic             done,
   output logic             seq_end,
   output logic [WIDTH-1:0] remaining
);

   bt_state_t        state_q;
   logic [WIDTH-1:0] cnt_q;
   logic             seq_end_q;
   logic             start;
   logic             last;
   logic             phase_zero;

   // The pattern generator fires on the same edge the counter is seen at zero.
   assign start = en && ((state_q == IDLE) || (state_q == COUNT)) && (cnt_q == '0);

   beep_pattern_gen #(
      .NB_W    (NB_W),
      .ON_CYC  (ON_CYC),
      .OFF_CYC (OFF_CYC)
   ) u_pattern (
      .clk_i        (clk),
      .rst_i        (rst),
      .clr_i        (!en),
      .start_i      (start),
      .pulses_i     (n_beeps),
      .b_o          (b),
      .last_o       (last),
      .phase_zero_o (phase_zero)
   );

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q   <= IDLE;
         cnt_q     <= '0;
         seq_end_q <= 1'b0;
      end else begin
         seq_end_q <= 1'b0;
         if (!en) begin
            state_q <= IDLE;
            cnt_q   <= v;
         end else begin
            case (state_q)
               IDLE, COUNT: begin
                  if (cnt_q != '0) begin
                     cnt_q   <= cnt_q - WIDTH'(1);
                     state_q <= COUNT;
                  end else begin
                     state_q <= BEEP_ON;
                  end
               end
               BEEP_ON: begin
                  if (phase_zero) begin
                     if (last) begin
                        seq_end_q <= 1'b1;
                        if (auto_reload) begin
                           cnt_q   <= v;
                           state_q <= COUNT;
                        end else begin
                           state_q <= DONE;
                        end
                     end else begin
                        state_q <= BEEP_OFF;
                     end
                  end
               end
               BEEP_OFF: begin
                  if (phase_zero) state_q <= BEEP_ON;
               end
               DONE:    state_q <= DONE;
               default: state_q <= IDLE;
            endcase
         end
      end
   end

   assign busy      = (state_q == COUNT) || (state_q == BEEP_ON) || (state_q == BEEP_OFF);
   assign done      = (state_q == DONE);
   assign seq_end   = seq_end_q;
   assign remaining = cnt_q;

endmodule
